// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-port synchronous SRAM between the fetch
//               stage (read-only) and the memory stage (read/write). One
//               access is outstanding at a time. Fetch starvation is bounded
//               by a data-grant streak counter, and fetch responses are
//               discarded on a branch flush.
// Options     : UNIFIED_MEM_ARBITER_PERF_EN enables grant and stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_req_valid,
    output logic                    fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0]   fetch_req_addr,
    output logic                    fetch_resp_valid,
    input  logic                    fetch_resp_ready,
    output logic [DATA_WIDTH-1:0]   fetch_resp_rdata,
    input  logic                    fetch_flush,
    input  logic                    data_req_valid,
    output logic                    data_req_ready,
    input  logic                    data_req_we,
    input  logic [ADDR_WIDTH-1:0]   data_req_addr,
    input  logic [DATA_WIDTH-1:0]   data_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] data_req_wstrb,
    output logic                    data_resp_valid,
    input  logic                    data_resp_ready,
    output logic [DATA_WIDTH-1:0]   data_resp_rdata,
    output logic                    sram_en,
    output logic [DATA_WIDTH/8-1:0] sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata,
    output logic [31:0]             perf_fetch_grants,
    output logic [31:0]             perf_data_grants,
    output logic [31:0]             perf_stall_cycles
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    state_t                state;
    owner_t                owner;
    logic [3:0]            streak;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  idle;
    logic                  fetch_grant;
    logic                  data_grant;
    logic                  resp_active;
    logic                  resp_accept;
    logic                  resp_kill;
    logic [DATA_WIDTH-1:0] resp_data;

    // Arbitration, SRAM port drive and response routing; every output is
    // gated by rst so that asserting reset silences the block immediately.
    always_comb begin
        idle        = rst && (state == S_IDLE);
        // Data wins by default; fetch wins when alone or when its wait has
        // hit the streak limit. A flush blocks any fetch grant this cycle.
        fetch_grant = idle && fetch_req_valid && !fetch_flush &&
                      ((streak == STREAK_MAX) || !data_req_valid);
        data_grant  = idle && data_req_valid && !fetch_grant;

        resp_active = rst && ((state == S_RESP) || (state == S_HOLD));
        resp_data   = (state == S_HOLD) ? rdata_q : sram_rdata;
        resp_kill   = (owner == OWN_FETCH) && fetch_flush;
        resp_accept = (owner == OWN_FETCH) ? fetch_resp_ready : data_resp_ready;

        fetch_req_ready  = fetch_grant;
        data_req_ready   = data_grant;

        fetch_resp_valid = resp_active && (owner == OWN_FETCH) && !fetch_flush;
        data_resp_valid  = resp_active && (owner == OWN_DATA);
        fetch_resp_rdata = fetch_resp_valid ? resp_data : '0;
        data_resp_rdata  = data_resp_valid  ? resp_data : '0;

        sram_en    = fetch_grant || data_grant;
        sram_we    = (data_grant && data_req_we) ? data_req_wstrb : '0;
        sram_wdata = (data_grant && data_req_we) ? data_req_wdata : '0;
        if (data_grant) begin
            sram_addr = data_req_addr;
        end else if (fetch_grant) begin
            sram_addr = fetch_req_addr;
        end else begin
            sram_addr = '0;
        end
    end

    // Access sequencer: IDLE issues a grant, RESP presents SRAM data, HOLD
    // replays the captured data until the owner accepts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            owner   <= OWN_NONE;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_grant) begin
                        owner <= OWN_FETCH;
                        state <= S_RESP;
                    end else if (data_grant && !data_req_we) begin
                        owner <= OWN_DATA;
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_kill || resp_accept) begin
                        owner <= OWN_NONE;
                        state <= S_IDLE;
                    end else begin
                        rdata_q <= sram_rdata;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (resp_kill || resp_accept) begin
                        owner <= OWN_NONE;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Streak of data grants made while a fetch was waiting; only IDLE cycles
    // update it so a fetch waiting across RESP/HOLD keeps its history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= 4'd0;
        end else if (state == S_IDLE) begin
            if (fetch_grant || !fetch_req_valid) begin
                streak <= 4'd0;
            end else if (data_grant && (streak != STREAK_MAX)) begin
                streak <= streak + 4'd1;
            end
        end
    end

`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    // Free-running grant and stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_grants <= 32'd0;
            perf_data_grants  <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (fetch_grant) begin
                perf_fetch_grants <= perf_fetch_grants + 32'd1;
            end
            if (data_grant) begin
                perf_data_grants <= perf_data_grants + 32'd1;
            end
            if ((fetch_req_valid || data_req_valid) && !(fetch_grant || data_grant)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`else
    assign perf_fetch_grants = 32'd0;
    assign perf_data_grants  = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
